// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared encodings for the memory-channel arbiter: FSM states, transaction
//   owner codes, grant-vector bit positions and a counter-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_READ_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IC   = 2'd1,
    OWN_DC   = 2'd2
  } arb_owner_e;

  // Bit positions inside the one-hot grant vector from arb_pick.
  localparam int GNT_IC = 0;
  localparam int GNT_DC = 1;

  // Beat counter width: clog2(beats), never narrower than one bit.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick
//   Two-way combinational picker for the memory arbiter.
//   Ports:
//     ic_valid  - I-cache request pending
//     dc_valid  - D-cache request pending
//     last_dc   - 1 if the most recent grant went to the D-cache
//     grant     - one-hot grant, bit GNT_IC / GNT_DC
//   A lone requester always wins. On a tie the requester that did not win
//   last time wins; holding last_dc at 0 therefore gives fixed D-cache priority.
import mem_arbiter_pkg::*;

module arb_pick (
  input  logic       ic_valid,
  input  logic       dc_valid,
  input  logic       last_dc,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (ic_valid && dc_valid) begin
      if (last_dc) grant[GNT_IC] = 1'b1;
      else         grant[GNT_DC] = 1'b1;
    end else if (dc_valid) begin
      grant[GNT_DC] = 1'b1;
    end else if (ic_valid) begin
      grant[GNT_IC] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one main-memory request/response channel between the I-cache
//   refill port (reads only) and the D-cache refill/writeback port (reads and
//   single-beat writes). One transaction is outstanding at a time; read bursts
//   return BEATS beats which are routed to the granted requester only.
//
//   Build option: define ARB_RR_EN for round-robin arbitration on ties;
//   otherwise the D-cache has fixed priority.
//
//   Ports:
//     clk, reset                       - clock, synchronous active-high reset
//     ic_req_*/ic_resp_*               - I-cache request and response beats
//     dc_req_*/dc_resp_*               - D-cache request and response beats
//     mem_req_*/mem_resp_*             - shared memory channel
//     busy                             - a transaction is in flight
//
//   state         | meaning
//   ARB_IDLE      | no transaction; arbitrate and capture the winner
//   ARB_ISSUE     | presenting the captured request to memory
//   ARB_READ_WAIT | forwarding read beats to the owner
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        grant;
  logic              last_dc;

  arb_pick u_pick (
    .ic_valid (ic_req_valid),
    .dc_valid (dc_req_valid),
    .last_dc  (last_dc),
    .grant    (grant)
  );

`ifdef ARB_RR_EN
  logic last_dc_q;

  // Pointer remembers the most recent winner; reset value means "I-cache won".
  always_ff @(posedge clk) begin
    if (reset) begin
      last_dc_q <= 1'b0;
    end else if (state_q == ARB_IDLE && (|grant)) begin
      last_dc_q <= grant[GNT_DC];
    end
  end

  assign last_dc = last_dc_q;
`else
  // Pretending the I-cache always won last makes the picker favour the D-cache.
  assign last_dc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mem_req_valid = 1'b0;
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    ic_resp_valid = 1'b0;
    dc_resp_valid = 1'b0;
    ic_resp_data  = '0;
    dc_resp_data  = '0;

    case (state_q)
      ARB_IDLE: begin
        if (grant[GNT_DC]) begin
          owner_d = OWN_DC;
          rw_d    = dc_req_rw;
          addr_d  = dc_req_addr;
          wdata_d = dc_req_wdata;
          state_d = ARB_ISSUE;
        end else if (grant[GNT_IC]) begin
          owner_d = OWN_IC;
          rw_d    = 1'b0;
          addr_d  = ic_req_addr;
          wdata_d = '0;
          state_d = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        // Accept is a pass-through of memory's ready, to the owner only.
        ic_req_ready  = (owner_q == OWN_IC) && mem_req_ready;
        dc_req_ready  = (owner_q == OWN_DC) && mem_req_ready;
        if (mem_req_ready) begin
          if (rw_q) begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
          end else begin
            state_d = ARB_READ_WAIT;
            cnt_d   = '0;
          end
        end
      end

      ARB_READ_WAIT: begin
        if (mem_resp_valid) begin
          if (owner_q == OWN_IC) begin
            ic_resp_valid = 1'b1;
            ic_resp_data  = mem_resp_data;
          end else if (owner_q == OWN_DC) begin
            dc_resp_valid = 1'b1;
            dc_resp_data  = mem_resp_data;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_req_rw    = rw_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign busy          = (state_q != ARB_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory request/response channel between the I-cache refill port and the D-cache refill/writeback port of the Riscv151 pipeline.
- Serialises transactions with one outstanding transaction at a time.
- Handles multi-beat read bursts and single-beat writes.
- Routes response beats back to the granted requester only.

Parameters:
- ADDR_W, 32, width of memory byte address.
- DATA_W, 128, width of one memory data beat.
- BEATS, 4, response beats per read burst (power of two, 1..16).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ic_req_valid  in  1  I-cache read request
- ic_req_ready  out  1  I-cache request accepted
- ic_req_addr  in  ADDR_W  I-cache burst base address
- ic_resp_valid  out  1  I-cache response beat valid
- ic_resp_data  out  DATA_W  I-cache response beat
- dc_req_valid  in  1  D-cache request
- dc_req_ready  out  1  D-cache request accepted
- dc_req_rw  in  1  1=write, 0=read
- dc_req_addr  in  ADDR_W  D-cache address
- dc_req_wdata  in  DATA_W  D-cache write data
- dc_resp_valid  out  1  D-cache response beat valid
- dc_resp_data  out  DATA_W  D-cache response beat
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  1=write
- mem_req_addr  out  ADDR_W  memory address
- mem_req_wdata  out  DATA_W  memory write data
- mem_resp_valid  in  1  memory read beat valid
- mem_resp_data  in  DATA_W  memory read beat
- busy  out  1  transaction in flight (IDLE not current state)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high.
- On reset:
  - FSM goes to IDLE and beat counter clears.
  - Grant register clears (owner = none).
  - All valid/ready outputs are 0, busy=0.
  - With ARB_RR_EN, last-winner pointer = ICACHE.
- Reset asserted mid-burst abandons the transaction. Remaining mem_resp beats are ignored (both resp_valid held 0).
- States: IDLE, ISSUE, READ_WAIT.
- IDLE:
  - Arbitrates among asserted req_valids and registers the winner (owner) plus its rw/addr/wdata.
  - Moves to ISSUE on the next edge.
  - No ready is asserted in IDLE.
- Arbitration, fixed priority: D-cache wins when both requesters are valid.
- ISSUE:
  - mem_req_valid=1, driven from the registered fields.
  - The owner's req_ready is asserted in the same cycle as mem_req_ready (combinational pass-through, owner only). The requester must hold its request stable until ready.
  - On mem_req_valid&&mem_req_ready: a write goes to IDLE; a read goes to READ_WAIT with beat counter=0.
- READ_WAIT:
  - Each mem_resp_valid forwards mem_resp_data combinationally to the owner's resp_data with the owner's resp_valid=1.
  - The non-owner's resp_valid is always 0.
  - The counter increments per beat. The beat with counter==BEATS-1 returns the FSM to IDLE and clears owner.
- mem_resp_valid outside READ_WAIT is ignored, with no forwarding.
- Request latency: earliest acceptance is 1 cycle after req_valid rises (IDLE→ISSUE). Back-to-back transactions have at least one IDLE cycle between them.
- A requester deasserting req_valid after grant is a protocol violation. The arbiter completes the issued transaction regardless.
- ic side: mem_req_rw is forced 0 for I-cache grants.
- Counter width is clog2(BEATS), minimum 1 bit. It wraps only via the terminal-beat transition, never by overflow.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests in IDLE, the requester that did not win the most recent grant wins.
  - The pointer updates at each grant.
  - A lone requester always wins.
- Undefined: fixed D-cache priority as above, and no pointer state exists.

Decomposition:
- Shared package/header: FSM state encodings (ARB_IDLE, ARB_ISSUE, ARB_READ_WAIT) and owner encodings (OWN_NONE, OWN_IC, OWN_DC), alongside the existing constant headers.
- One natural sub-module: arb_pick, a 2-way combinational picker. Inputs are the two valids and the rr pointer; output is the one-hot grant. It is instantiated once.
- Sequential state uses the team's REGISTER_R-style reset registers.

Test Plan:
- I-cache read only:
  - Stimulus: ic_req addr 0x1000, mem_req_ready=1, then 4 resp beats A,B,C,D.
  - Response: mem_req_addr=0x1000, rw=0; ic_resp_valid on exactly 4 cycles carrying A..D; dc_resp_valid stays 0; busy drops after D.
- Simultaneous requests, fixed priority:
  - Stimulus: ic and dc reads in the same cycle.
  - Response: dc granted first and its 4 beats complete; then ic granted with a 1-cycle IDLE gap.
- D-cache write with backpressure:
  - Stimulus: dc write addr 0x2000, wdata 0xDEAD..., mem_req_ready low for 3 cycles.
  - Response: mem_req_valid held with stable fields; dc_req_ready pulses once, on the ready cycle; FSM returns to IDLE with no READ_WAIT.
- Response filtering:
  - Stimulus: stray mem_resp_valid while IDLE and while in ISSUE.
  - Response: no resp_valid on either port.
- Reset mid-burst:
  - Stimulus: reset asserted after beat 2 of 4.
  - Response: next cycle all outputs 0, busy=0; remaining beats ignored; a new ic request then completes normally.
- ARB_RR_EN:
  - Stimulus: both ports request continuously for 4 transactions.
  - Response: grant order DC, IC, DC, IC after reset (pointer=ICACHE).
